// File: rtl/fighter_pkg.sv
// ============================================================================
//  fighter_pkg
//  Shared action-state encoding, button bit indices and tuning constants.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package fighter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WALK    = 3'd1,
    ST_JUMP    = 3'd2,
    ST_WINDUP  = 3'd3,
    ST_ACTIVE  = 3'd4,
    ST_RECOVER = 3'd5,
    ST_SHIELD  = 3'd6,
    ST_HITSTUN = 3'd7
  } fighter_state_e;

  // Bit positions inside controller_inputs; bit 0 carries nothing.
  localparam int BTN_DOWN   = 1;
  localparam int BTN_RIGHT  = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_LEFT   = 4;
  localparam int BTN_ATTACK = 5;
  localparam int BTN_SHIELD = 6;

  localparam logic [9:0] X_MIN    = 10'd0;
  localparam logic [9:0] X_MAX    = 10'd608;
  localparam logic [9:0] X_RESET  = 10'd300;
  localparam logic [9:0] Y_GROUND = 10'd300;

  localparam logic [3:0] WALK_STEP = 4'd2;
  localparam logic [3:0] KNOCKBACK = 4'd4;

  localparam logic signed [7:0] JUMP_V0 = 8'sd12;
  localparam logic signed [7:0] GRAVITY = 8'sd1;

  localparam logic [2:0] WINDUP_FRAMES  = 3'd3;
  localparam logic [2:0] ACTIVE_FRAMES  = 3'd2;
  localparam logic [2:0] RECOVER_FRAMES = 3'd4;
  localparam logic [2:0] HITSTUN_FRAMES = 3'd6;

  function automatic logic [9:0] clamp_x(input logic signed [11:0] pos);
    logic [9:0] res;
    if (pos < 12'sd0) begin
      res = X_MIN;
    end else if (pos > $signed({2'b00, X_MAX})) begin
      res = X_MAX;
    end else begin
      res = pos[9:0];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fighter_action_fsm_if.sv
// ============================================================================
//  fighter_action_fsm_if
//  Tick/controller/hit inputs and registered sprite/status outputs of a fighter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface fighter_action_fsm_if;

  logic              frame_tick_i;
  logic [6:0]        controller_inputs_i;
  logic              hit_in_i;

  logic [9:0]        player_x_o;
  logic [9:0]        player_y_o;
  logic [2:0]        state_o;
  logic              attack_active_o;
  logic              shield_active_o;
  logic              facing_right_o;
  logic              hit_pending_o;
  logic signed [7:0] vy_o;

  modport master (
    output frame_tick_i, controller_inputs_i, hit_in_i,
    input  player_x_o, player_y_o, state_o, attack_active_o,
           shield_active_o, facing_right_o, hit_pending_o, vy_o
  );

  modport slave (
    input  frame_tick_i, controller_inputs_i, hit_in_i,
    output player_x_o, player_y_o, state_o, attack_active_o,
           shield_active_o, facing_right_o, hit_pending_o, vy_o
  );

endinterface

`default_nettype wire

// File: rtl/fighter_frame_timer.sv
// ============================================================================
//  fighter_frame_timer
//  Loadable, tick-enabled down counter; done_o is high while the count is zero.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fighter_frame_timer (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       tick_i,
  input  wire logic       load_i,
  input  wire logic [2:0] load_val_i,
  output logic            done_o
);

  logic [2:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 3'd0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (tick_i && (count_q != 3'd0)) begin
      count_q <= count_q - 3'd1;
    end
  end

  assign done_o = (count_q == 3'd0);

endmodule

`default_nettype wire

// File: rtl/fighter_action_fsm.sv
// ============================================================================
//  fighter_action_fsm
//  Per-frame fighter action state machine: walk, jump, attack, shield, hitstun.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fighter_action_fsm
  import fighter_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst,
  fighter_action_fsm_if.slave   bus
);

  localparam logic signed [11:0] STEP_S  = {8'd0, WALK_STEP};
  localparam logic signed [11:0] KNOCK_S = {8'd0, KNOCKBACK};

  fighter_state_e    state_q, state_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic signed [7:0] vy_q, vy_d;
  logic              facing_q, facing_d;
  logic              pend_q, pend_d;
  logic              attack_q, attack_d;
  logic              shield_q, shield_d;

  logic              tick;
  logic              btn_r, btn_l, btn_up, btn_atk, btn_sh;
  logic              walk_one;
  logic signed [11:0] x_ext, vy_ext, y_jump;
  logic [9:0]        x_walk, x_knock;
  logic              landing;
  logic              tmr_load;
  logic [2:0]        tmr_val;
  logic              tmr_done;
  logic              unused_btns;

  assign tick    = bus.frame_tick_i;
  assign btn_r   = bus.controller_inputs_i[BTN_RIGHT];
  assign btn_l   = bus.controller_inputs_i[BTN_LEFT];
  assign btn_up  = bus.controller_inputs_i[BTN_UP];
  assign btn_atk = bus.controller_inputs_i[BTN_ATTACK];
  assign btn_sh  = bus.controller_inputs_i[BTN_SHIELD];
  assign unused_btns = ^{bus.controller_inputs_i[BTN_DOWN], bus.controller_inputs_i[0]};

  // Horizontal candidates; left+right together cancels out.
  assign walk_one = btn_l ^ btn_r;
  assign x_ext    = $signed({2'b00, x_q});
  assign x_walk   = !walk_one ? x_q :
                    (btn_r ? clamp_x(x_ext + STEP_S) : clamp_x(x_ext - STEP_S));
  assign x_knock  = facing_q ? clamp_x(x_ext - KNOCK_S) : clamp_x(x_ext + KNOCK_S);

  assign vy_ext  = {{4{vy_q[7]}}, vy_q};
  assign y_jump  = $signed({2'b00, y_q}) - vy_ext;
  assign landing = vy_q[7] && (y_jump >= $signed({2'b00, Y_GROUND}));

  fighter_frame_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .tick_i     (tick),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= X_RESET;
      y_q      <= Y_GROUND;
      vy_q     <= 8'sd0;
      facing_q <= 1'b1;
      pend_q   <= 1'b0;
      attack_q <= 1'b0;
      shield_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
      facing_q <= facing_d;
      pend_q   <= pend_d;
      attack_q <= attack_d;
      shield_q <= shield_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vy_d     = vy_q;
    facing_d = facing_q;
    pend_d   = pend_q;
    tmr_load = 1'b0;
    tmr_val  = 3'd0;

    if (tick) begin
      case (state_q)
        ST_IDLE, ST_WALK: begin
          if (pend_q) begin
            state_d  = ST_HITSTUN;
            pend_d   = 1'b0;
            x_d      = x_knock;
            tmr_load = 1'b1;
            tmr_val  = HITSTUN_FRAMES - 3'd1;
          end else if (btn_atk) begin
            state_d  = ST_WINDUP;
            tmr_load = 1'b1;
            tmr_val  = WINDUP_FRAMES - 3'd1;
          end else if (btn_sh) begin
            state_d = ST_SHIELD;
          end else if (btn_up) begin
            // Launch tick already applies the first upward step.
            state_d = ST_JUMP;
            y_d     = Y_GROUND - {2'b00, JUMP_V0};
            vy_d    = JUMP_V0 - GRAVITY;
          end else if (walk_one) begin
            state_d  = ST_WALK;
            x_d      = x_walk;
            facing_d = btn_r;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_JUMP: begin
          x_d = x_walk;
          if (walk_one) begin
            facing_d = btn_r;
          end
          if (landing) begin
            state_d = ST_IDLE;
            y_d     = Y_GROUND;
            vy_d    = 8'sd0;
          end else begin
            y_d  = y_jump[9:0];
            vy_d = vy_q - GRAVITY;
          end
        end

        ST_WINDUP, ST_ACTIVE, ST_RECOVER: begin
          if (pend_q) begin
            state_d  = ST_HITSTUN;
            pend_d   = 1'b0;
            x_d      = x_knock;
            tmr_load = 1'b1;
            tmr_val  = HITSTUN_FRAMES - 3'd1;
          end else if (tmr_done) begin
            if (state_q == ST_WINDUP) begin
              state_d  = ST_ACTIVE;
              tmr_load = 1'b1;
              tmr_val  = ACTIVE_FRAMES - 3'd1;
            end else if (state_q == ST_ACTIVE) begin
              state_d  = ST_RECOVER;
              tmr_load = 1'b1;
              tmr_val  = RECOVER_FRAMES - 3'd1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        ST_SHIELD: begin
          pend_d = 1'b0;
          if (!btn_sh) begin
            state_d = ST_IDLE;
          end
        end

        ST_HITSTUN: begin
          pend_d = 1'b0;
          if (tmr_done) begin
            state_d = ST_IDLE;
          end else begin
            x_d = x_knock;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // A hit arriving on a tick survives that tick's consumption.
    pend_d = pend_d | bus.hit_in_i;
  end

  always_comb begin
    attack_d = (state_d == ST_ACTIVE);
    shield_d = (state_d == ST_SHIELD);
  end

  assign bus.player_x_o      = x_q;
  assign bus.player_y_o      = y_q;
  assign bus.state_o         = state_q;
  assign bus.attack_active_o = attack_q;
  assign bus.shield_active_o = shield_q;
  assign bus.facing_right_o  = facing_q;
  assign bus.hit_pending_o   = pend_q;
  assign bus.vy_o            = vy_q;

endmodule

`default_nettype wire

// File: tb/tb_fighter_action_fsm.sv
// ============================================================================
//  tb_fighter_action_fsm
//  Scoreboard bench: reference model predicts each tick/reset, monitor compares.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fighter_action_fsm;
  import fighter_pkg::*;

  localparam logic [6:0] B_RIGHT  = 7'h04;
  localparam logic [6:0] B_UP     = 7'h08;
  localparam logic [6:0] B_LEFT   = 7'h10;
  localparam logic [6:0] B_ATTACK = 7'h20;
  localparam logic [6:0] B_SHIELD = 7'h40;

  localparam int S_IDLE = 0, S_WALK = 1, S_JUMP = 2, S_WINDUP = 3;
  localparam int S_ACTIVE = 4, S_RECOVER = 5, S_SHIELD = 6, S_HITSTUN = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fighter_action_fsm_if bus ();

  fighter_action_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int st;
    int x;
    int y;
    int vy;
    int atk;
    int shd;
    int fr;
    int pend;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Reference model state, counted in visible ticks per phase.
  int m_st, m_x, m_y, m_vy, m_left, m_fr, m_pend;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampx(input int v);
    return (v < 0) ? 0 : ((v > 608) ? 608 : v);
  endfunction

  task automatic m_knock();
    m_x = clampx(m_fr ? m_x - 4 : m_x + 4);
  endtask

  task automatic m_hit();
    m_st = S_HITSTUN; m_left = 6; m_pend = 0; m_knock();
  endtask

  task automatic m_push();
    exp_t e;
    e.st = m_st; e.x = m_x; e.y = m_y; e.vy = m_vy;
    e.atk = (m_st == S_ACTIVE) ? 1 : 0;
    e.shd = (m_st == S_SHIELD) ? 1 : 0;
    e.fr = m_fr; e.pend = m_pend;
    sbq.push_back(e);
  endtask

  task automatic model_step(input bit tick, input logic [6:0] c, input bit hit, input bit r);
    bit rt, lf, up, at, sh;
    int ny;
    rt = c[2]; up = c[3]; lf = c[4]; at = c[5]; sh = c[6];
    if (r) begin
      m_st = S_IDLE; m_x = 300; m_y = 300; m_vy = 0; m_left = 0; m_fr = 1; m_pend = 0;
      m_push();
    end else if (!tick) begin
      if (hit) m_pend = 1;
    end else begin
      if (m_st == S_IDLE || m_st == S_WALK) begin
        if (m_pend != 0) m_hit();
        else if (at) begin m_st = S_WINDUP; m_left = 3; end
        else if (sh) m_st = S_SHIELD;
        else if (up) begin m_st = S_JUMP; m_y = 300 - 12; m_vy = 11; end
        else if (lf != rt) begin
          m_st = S_WALK; m_x = clampx(rt ? m_x + 2 : m_x - 2); m_fr = rt;
        end else m_st = S_IDLE;
      end else if (m_st == S_JUMP) begin
        if (lf != rt) begin m_x = clampx(rt ? m_x + 2 : m_x - 2); m_fr = rt; end
        ny = m_y - m_vy;
        if (m_vy < 0 && ny >= 300) begin m_y = 300; m_vy = 0; m_st = S_IDLE; end
        else begin m_y = ny; m_vy = m_vy - 1; end
      end else if (m_st == S_WINDUP || m_st == S_ACTIVE || m_st == S_RECOVER) begin
        if (m_pend != 0) m_hit();
        else begin
          m_left--;
          if (m_left == 0) begin
            if (m_st == S_WINDUP) begin m_st = S_ACTIVE; m_left = 2; end
            else if (m_st == S_ACTIVE) begin m_st = S_RECOVER; m_left = 4; end
            else m_st = S_IDLE;
          end
        end
      end else if (m_st == S_SHIELD) begin
        m_pend = 0;
        if (!sh) m_st = S_IDLE;
      end else begin
        m_pend = 0;
        m_left--;
        if (m_left == 0) m_st = S_IDLE;
        else m_knock();
      end
      if (hit) m_pend = 1;
      m_push();
    end
  endtask

  // Inputs change 1 time unit after a rising edge; returns just after the next edge.
  task automatic cyc(input bit tick, input logic [6:0] c, input bit hit, input bit r);
    bus.frame_tick_i        = tick;
    bus.controller_inputs_i = c;
    bus.hit_in_i            = hit;
    rst                     = r;
    model_step(tick, c, hit, r);
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n, input logic [6:0] c);
    repeat (n) begin
      cyc(1'b1, c, 1'b0, 1'b0);
      cyc(1'b0, c, 1'b0, 1'b0);
    end
  endtask

  bit tick_s = 1'b0;
  bit rst_s  = 1'b0;

  always @(posedge clk) begin
    tick_s = bus.frame_tick_i;
    rst_s  = rst;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (tick_s || rst_s) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got no expectation at %0t", $time);
      end else begin
        e = sbq.pop_front();
        cmp("state", int'(bus.state_o), e.st);
        cmp("player_x", int'(bus.player_x_o), e.x);
        cmp("player_y", int'(bus.player_y_o), e.y);
        cmp("vy", int'(bus.vy_o), e.vy);
        cmp("attack_active", int'(bus.attack_active_o), e.atk);
        cmp("shield_active", int'(bus.shield_active_o), e.shd);
        cmp("facing_right", int'(bus.facing_right_o), e.fr);
        cmp("hit_pending", int'(bus.hit_pending_o), e.pend);
      end
    end
  end

  initial begin : driver
    logic [6:0] c;
    bit tk, ht, rr;
    bus.frame_tick_i        = 1'b0;
    bus.controller_inputs_i = 7'd0;
    bus.hit_in_i            = 1'b0;

    cyc(1'b0, 7'd0, 1'b0, 1'b1);
    cyc(1'b0, 7'd0, 1'b0, 1'b1);
    cmp("reset_x", int'(bus.player_x_o), 300);
    cmp("reset_y", int'(bus.player_y_o), 300);
    cmp("reset_state", int'(bus.state_o), S_IDLE);
    cmp("reset_facing", int'(bus.facing_right_o), 1);

    ticks(10, B_RIGHT);
    cmp("walk10_x", int'(bus.player_x_o), 320);
    cmp("walk10_state", int'(bus.state_o), S_WALK);
    cmp("walk10_facing", int'(bus.facing_right_o), 1);

    ticks(1, B_RIGHT | B_LEFT);
    cmp("both_state", int'(bus.state_o), S_IDLE);
    cmp("both_x", int'(bus.player_x_o), 320);
    cmp("both_facing", int'(bus.facing_right_o), 1);

    cyc(1'b0, 7'd0, 1'b0, 1'b1);
    ticks(1, B_UP);
    cmp("jump_t1_y", int'(bus.player_y_o), 288);
    ticks(11, 7'd0);
    cmp("jump_t12_y", int'(bus.player_y_o), 222);
    ticks(1, 7'd0);
    cmp("jump_t13_y", int'(bus.player_y_o), 222);
    ticks(11, 7'd0);
    cmp("jump_t24_state", int'(bus.state_o), S_JUMP);
    ticks(1, 7'd0);
    cmp("jump_t25_y", int'(bus.player_y_o), 300);
    cmp("jump_t25_state", int'(bus.state_o), S_IDLE);

    ticks(1, B_ATTACK);
    cmp("atk_t1_state", int'(bus.state_o), S_WINDUP);
    ticks(2, 7'd0);
    cmp("atk_t3_state", int'(bus.state_o), S_WINDUP);
    cmp("atk_t3_active", int'(bus.attack_active_o), 0);
    ticks(1, 7'd0);
    cmp("atk_t4_active", int'(bus.attack_active_o), 1);
    ticks(1, 7'd0);
    cmp("atk_t5_active", int'(bus.attack_active_o), 1);
    ticks(1, 7'd0);
    cmp("atk_t6_state", int'(bus.state_o), S_RECOVER);
    ticks(3, 7'd0);
    cmp("atk_t9_state", int'(bus.state_o), S_RECOVER);
    ticks(1, 7'd0);
    cmp("atk_t10_state", int'(bus.state_o), S_IDLE);

    ticks(1, B_SHIELD);
    cyc(1'b0, B_SHIELD, 1'b1, 1'b0);
    cmp("shield_pend_set", int'(bus.hit_pending_o), 1);
    ticks(1, B_SHIELD);
    cmp("shield_state", int'(bus.state_o), S_SHIELD);
    cmp("shield_x", int'(bus.player_x_o), 300);
    cmp("shield_pend_clr", int'(bus.hit_pending_o), 0);
    ticks(1, 7'd0);
    cmp("shield_exit", int'(bus.state_o), S_IDLE);

    ticks(170, B_LEFT);
    cmp("left_clamp_x", int'(bus.player_x_o), 0);
    ticks(1, B_RIGHT);
    cmp("kb_start_x", int'(bus.player_x_o), 2);
    cyc(1'b0, 7'd0, 1'b1, 1'b0);
    ticks(1, 7'd0);
    cmp("kb_t1_state", int'(bus.state_o), S_HITSTUN);
    cmp("kb_t1_x", int'(bus.player_x_o), 0);
    ticks(5, 7'd0);
    cmp("kb_t6_state", int'(bus.state_o), S_HITSTUN);
    ticks(1, 7'd0);
    cmp("kb_t7_state", int'(bus.state_o), S_IDLE);

    ticks(320, B_RIGHT);
    cmp("right_clamp_x", int'(bus.player_x_o), 608);

    ticks(1, 7'd0);
    ticks(5, B_UP);
    cmp("midjump_y", int'(bus.player_y_o), 250);
    cyc(1'b1, B_UP | B_ATTACK, 1'b1, 1'b1);
    cmp("rstjump_y", int'(bus.player_y_o), 300);
    cmp("rstjump_x", int'(bus.player_x_o), 300);
    cmp("rstjump_state", int'(bus.state_o), S_IDLE);
    cmp("rstjump_vy", int'(bus.vy_o), 0);
    cmp("rstjump_pend", int'(bus.hit_pending_o), 0);

    for (int i = 0; i < 4000; i++) begin
      tk = ($urandom_range(0, 2) == 0);
      c  = 7'($urandom);
      if ($urandom_range(0, 3) != 0) c[5] = 1'b0;
      if ($urandom_range(0, 2) != 0) c[6] = 1'b0;
      if ($urandom_range(0, 3) != 0) c[3] = 1'b0;
      ht = ($urandom_range(0, 15) == 0);
      rr = ($urandom_range(0, 399) == 0);
      cyc(tk, c, ht, rr);
    end

    cyc(1'b0, 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    cmp("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
